// File: rtl/xs3_gray_decade_counter.sv
// ----------------------------------------------------------------------------
// xs3_gray_decade_counter
//   Synchronous decade counter whose state is presented as the excess-3 Gray
//   code digit expected by a Gray-to-decimal one-of-ten decoder. The code
//   bits come straight from flops, and adjacent digits (including the 9<->0
//   wrap) differ in exactly one bit, so the decoder never sees a transient.
//
// Parameters
//   START_DIGIT  digit (0-9) loaded by reset; values above 9 fall back to 0
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high (overrides load and en)
//   en          count enable, one step per cycle
//   up          direction: 1 = increment, 0 = decrement
//   load        parallel load strobe
//   load_digit  binary digit to load (0-9 accepted, 10-15 rejected)
//   D,C,B,A     registered code bits, D is the MSB
//   digit       registered binary mirror of the current digit
//   tc          combinational terminal count, drives en of the next decade
//   load_err    registered one-cycle pulse for a rejected load
// ----------------------------------------------------------------------------
module xs3_gray_decade_counter #(
   parameter int unsigned START_DIGIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_digit,
   output logic       D,
   output logic       C,
   output logic       B,
   output logic       A,
   output logic [3:0] digit,
   output logic       tc,
   output logic       load_err
);

   localparam logic [3:0] RST_DIGIT = (START_DIGIT > 9) ? 4'd0 : 4'(START_DIGIT);

   // Digit -> {D,C,B,A}. The default is unreachable because digit_d is
   // always 0-9; it maps to the code for 0 so no non-table code can appear.
   function automatic logic [3:0] xs3_code(input logic [3:0] d);
      logic [3:0] c;
      case (d)
         4'd0:    c = 4'b0010;
         4'd1:    c = 4'b0110;
         4'd2:    c = 4'b0111;
         4'd3:    c = 4'b0101;
         4'd4:    c = 4'b0100;
         4'd5:    c = 4'b1100;
         4'd6:    c = 4'b1101;
         4'd7:    c = 4'b1111;
         4'd8:    c = 4'b1110;
         4'd9:    c = 4'b1010;
         default: c = 4'b0010;
      endcase
      return c;
   endfunction

   logic [3:0] digit_q, digit_d;
   logic [3:0] code_q, code_d;
   logic       load_err_q, load_err_d;

   always_comb begin
      digit_d    = digit_q;
      load_err_d = 1'b0;
      if (load) begin
         // A rejected load still blocks counting for this cycle.
         if (load_digit <= 4'd9) digit_d    = load_digit;
         else                    load_err_d = 1'b1;
      end else if (en) begin
         if (up) digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
         else    digit_d = (digit_q == 4'd0 || digit_q > 4'd9) ? 4'd9 : digit_q - 4'd1;
      end
      // Code is derived from the next digit so both registers load together.
      code_d = xs3_code(digit_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_q    <= RST_DIGIT;
         code_q     <= xs3_code(RST_DIGIT);
         load_err_q <= 1'b0;
      end else begin
         digit_q    <= digit_d;
         code_q     <= code_d;
         load_err_q <= load_err_d;
      end
   end

   assign D        = code_q[3];
   assign C        = code_q[2];
   assign B        = code_q[1];
   assign A        = code_q[0];
   assign digit    = digit_q;
   assign load_err = load_err_q;
   assign tc       = en & ~load & ((up & (digit_q == 4'd9)) | (~up & (digit_q == 4'd0)));

endmodule

// File: tb/tb_xs3_gray_decade_counter.sv
// ----------------------------------------------------------------------------
// tb_xs3_gray_decade_counter
//   Directed vectors with hand-computed expectations are pushed into a
//   scoreboard queue as they are driven; a monitor process pops each entry,
//   checks tc against the inputs of that cycle and the registered outputs
//   after the following edge. A two-digit cascade is checked afterwards.
// ----------------------------------------------------------------------------
module tb_xs3_gray_decade_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
   logic [3:0] load_digit = 4'd0;
   logic       D, C, B, A, tc, load_err;
   logic [3:0] digit;

   // Second and third instances share stimulus; only their reset state is used.
   logic       D7, C7, B7, A7, tc7, le7;
   logic [3:0] digit7;
   logic       Dx, Cx, Bx, Ax, tcx, lex;
   logic [3:0] digitx;

   // Cascade pair
   logic       c_rst = 1'b0, c_en = 1'b0;
   logic       uD, uC, uB, uA, u_tc, u_le;
   logic [3:0] u_digit;
   logic       tD, tC, tB, tA, t_tc, t_le;
   logic [3:0] t_digit;

   int errors = 0;
   int checks = 0;

   localparam logic [3:0] CODE [10] = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010};

   always #5 clk = ~clk;

   xs3_gray_decade_counter #(.START_DIGIT(0)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_digit(load_digit),
      .D(D), .C(C), .B(B), .A(A), .digit(digit), .tc(tc), .load_err(load_err));

   xs3_gray_decade_counter #(.START_DIGIT(7)) dut7 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_digit(load_digit),
      .D(D7), .C(C7), .B(B7), .A(A7), .digit(digit7), .tc(tc7), .load_err(le7));

   xs3_gray_decade_counter #(.START_DIGIT(12)) dutx (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_digit(load_digit),
      .D(Dx), .C(Cx), .B(Bx), .A(Ax), .digit(digitx), .tc(tcx), .load_err(lex));

   xs3_gray_decade_counter #(.START_DIGIT(0)) units (
      .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0), .load_digit(4'd0),
      .D(uD), .C(uC), .B(uB), .A(uA), .digit(u_digit), .tc(u_tc), .load_err(u_le));

   xs3_gray_decade_counter #(.START_DIGIT(0)) tens (
      .clk(clk), .rst(c_rst), .en(u_tc), .up(1'b1), .load(1'b0), .load_digit(4'd0),
      .D(tD), .C(tC), .B(tB), .A(tA), .digit(t_digit), .tc(t_tc), .load_err(t_le));

   typedef struct {
      string      name;
      logic       tc;     // tc expected with this cycle's inputs, before the edge
      logic [3:0] dig;    // digit expected after the edge
      logic       err;    // load_err expected after the edge
      logic       step;   // edge is a count step: check Hamming distance 1
   } exp_t;

   exp_t sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // Drive one cycle of inputs after the active edge and queue its expectation.
   task automatic drive(input logic r, input logic e, input logic u, input logic l,
                        input logic [3:0] ld, input logic [3:0] xd, input logic xe,
                        input logic xtc, input logic st, input string nm);
      exp_t x;
      @(posedge clk); #2;
      rst = r; en = e; up = u; load = l; load_digit = ld;
      x.name = nm; x.tc = xtc; x.dig = xd; x.err = xe; x.step = st;
      sb.push_back(x);
   endtask

   // Monitor: tc at the negedge, registered outputs 1 time unit after the edge.
   initial begin : monitor
      exp_t       x;
      logic [3:0] prev;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            x = sb.pop_front();
            check({x.name, ".tc"}, 32'(tc), 32'(x.tc));
            prev = {D, C, B, A};
            @(posedge clk); #1;
            check({x.name, ".digit"}, 32'(digit), 32'(x.dig));
            check({x.name, ".dcba"}, 32'({D, C, B, A}), 32'(CODE[x.dig]));
            check({x.name, ".load_err"}, 32'(load_err), 32'(x.err));
            if (x.step)
               check({x.name, ".hamming"}, $countones(prev ^ {D, C, B, A}), 1);
         end
      end
   end

   initial begin : stim
      int wait_cnt;
      //    rst en up ld  ldd  dig  err tc step
      drive(1, 1, 1, 1, 4'd3, 4'd0, 0, 0, 0, "rst0");
      drive(1, 1, 1, 1, 4'd3, 4'd0, 0, 0, 0, "rst1");
      // Up sweep of 12 from 0; tc is high only while the digit is 9.
      drive(0, 1, 1, 0, 4'd0, 4'd1, 0, 0, 1, "up1");
      // Reset state of the other instances is still visible here.
      check("start7.digit", 32'(digit7), 32'd7);
      check("start7.dcba", 32'({D7, C7, B7, A7}), 32'b1111);
      check("start12.digit", 32'(digitx), 32'd0);
      check("start12.dcba", 32'({Dx, Cx, Bx, Ax}), 32'b0010);
      drive(0, 1, 1, 0, 4'd0, 4'd2, 0, 0, 1, "up2");
      drive(0, 1, 1, 0, 4'd0, 4'd3, 0, 0, 1, "up3");
      drive(0, 1, 1, 0, 4'd0, 4'd4, 0, 0, 1, "up4");
      drive(0, 1, 1, 0, 4'd0, 4'd5, 0, 0, 1, "up5");
      drive(0, 1, 1, 0, 4'd0, 4'd6, 0, 0, 1, "up6");
      drive(0, 1, 1, 0, 4'd0, 4'd7, 0, 0, 1, "up7");
      drive(0, 1, 1, 0, 4'd0, 4'd8, 0, 0, 1, "up8");
      drive(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 1, "up9");
      drive(0, 1, 1, 0, 4'd0, 4'd0, 0, 1, 1, "upwrap");
      drive(0, 1, 1, 0, 4'd0, 4'd1, 0, 0, 1, "up1b");
      drive(0, 1, 1, 0, 4'd0, 4'd2, 0, 0, 1, "up2b");
      // Load 1 with en high, then count down through the wrap and turn around.
      drive(0, 1, 1, 1, 4'd1, 4'd1, 0, 0, 0, "ld1");
      drive(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 1, "dn0");
      drive(0, 1, 0, 0, 4'd0, 4'd9, 0, 1, 1, "dnwrap");
      drive(0, 1, 0, 0, 4'd0, 4'd8, 0, 0, 1, "dn8");
      drive(0, 1, 1, 0, 4'd0, 4'd9, 0, 0, 1, "turn9");
      // Load beats count and masks tc even at digit 9 counting up.
      drive(0, 1, 1, 1, 4'd5, 4'd5, 0, 0, 0, "ld5");
      drive(0, 1, 1, 1, 4'd12, 4'd5, 1, 0, 0, "badld");
      drive(0, 0, 1, 0, 4'd0, 4'd5, 0, 0, 0, "hold");
      drive(0, 1, 1, 1, 4'd15, 4'd5, 1, 0, 0, "badld2");
      drive(0, 1, 1, 1, 4'd10, 4'd5, 1, 0, 0, "badld3");
      drive(0, 1, 1, 0, 4'd0, 4'd6, 0, 0, 1, "up6c");
      // Reset at digit 6 overrides a valid load and en.
      drive(1, 1, 1, 1, 4'd3, 4'd0, 0, 0, 0, "midrst");
      drive(0, 1, 1, 0, 4'd0, 4'd1, 0, 0, 1, "resume");
      drive(0, 0, 0, 0, 4'd0, 4'd1, 0, 0, 0, "hold2");
      drive(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 1, "dn0b");
      drive(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "idle");

      wait_cnt = 0;
      while (sb.size() != 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      @(posedge clk); #2;
      check("sb_drained", 32'(sb.size()), 32'd0);

      // Cascade: units.tc drives tens.en; 100 steps return to 00.
      c_rst = 1'b1;
      @(posedge clk); #2;
      c_rst = 1'b0; c_en = 1'b1;
      check("casc.reset", 32'({t_digit, u_digit}), 32'h00);
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         check($sformatf("casc%0d", i), 32'({t_digit, u_digit}),
               32'({4'((i / 10) % 10), 4'(i % 10)}));
      end
      check("casc.dcba", 32'({tD, tC, tB, tA, uD, uC, uB, uA}), 32'h22);
      c_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Every code presented by the main counter must be a table entry.
   always @(negedge clk) begin
      if (!$isunknown({D, C, B, A}))
         assert ({D, C, B, A} inside {4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                      4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010})
         else $error("illegal code %b", {D, C, B, A});
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/xs3_gray_decade_counter.md
Name: xs3_gray_decade_counter

Overview:
- Synchronous decade counter that produces the excess-3 Gray code digit consumed by the Gray-to-decimal one-of-ten decoder.
- Drives the decoder's D, C, B and A inputs directly from flops, so they are glitch-free, and exactly one bit changes per count step, including wrap.
- Supports up/down counting, parallel load and cascade terminal count for multi-digit chains.

Parameters:
- START_DIGIT, 0, decimal digit (0-9) held after reset. Values above 9 are illegal; the implementation forces 0 in that case.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe
- load_digit  input  4  binary digit to load (0-9 valid)
- D  output  1  code bit 3 (MSB), registered
- C  output  1  code bit 2, registered
- B  output  1  code bit 1, registered
- A  output  1  code bit 0 (LSB), registered
- digit  output  4  binary mirror of current digit, registered
- tc  output  1  terminal count, combinational, for cascade
- load_err  output  1  one-cycle pulse: rejected load, registered

Behaviour:
- Code map, digit -> {D,C,B,A}:
  - 0=0010, 1=0110, 2=0111, 3=0101, 4=0100
  - 5=1100, 6=1101, 7=1111, 8=1110, 9=1010
- Reset:
  - rst is sampled on the rising edge of clk.
  - digit = START_DIGIT; {D,C,B,A} = code(START_DIGIT); load_err = 0.
  - rst overrides load and en in the same cycle.
- Priority per edge: rst > load > en > hold.
- Load:
  - Applies when load=1 and load_digit<=9.
  - Next cycle: digit = load_digit and {D,C,B,A} = code(load_digit); load_err = 0.
  - en is ignored that cycle.
- Invalid load:
  - Applies when load=1 and load_digit>=10.
  - State holds and is not incremented, even if en=1.
  - load_err = 1 for exactly one cycle, then 0 unless the invalid load repeats.
- Count up (en=1, up=1, load=0): digit goes 0->1->...->9->0. Wrap is 1010 -> 0010.
- Count down (en=1, up=0, load=0): digit goes 9->8->...->0->9. Wrap is 0010 -> 1010.
- Latency: one cycle from sampled control to updated outputs.
- Gray property: every count step changes exactly one of D, C, B, A.
- No intermediate code may ever appear on D, C, B, A, because the downstream decoder's outputs are active-low strobes.
- Code 0000 and all other non-table codes must never be produced.
- Consistency: digit and {D,C,B,A} always encode the same value.
  - They may be held as two registers or as one register with a registered mirror; either way they update on the same edge.
- tc = en & ~load & ((up & digit==9) | (~up & digit==0)).
  - Purely combinational from the current state and inputs.
  - Drives en of the next decade.
- Direction change mid-count takes effect on the next enabled edge; no extra or skipped step.
- en=0 and load=0: all outputs hold.

Test Plan:
- Reset: START_DIGIT=0, hold rst 2 cycles while en=1 and load=1 -> digit=0, DCBA=0010, load_err=0. Repeat with START_DIGIT=7 -> DCBA=1111.
- Up sweep: en=1, up=1 for 12 cycles from 0 -> DCBA goes 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 0010, 0110, 0111.
  - tc=1 only during the cycle digit=9.
  - Each step has Hamming distance 1.
- Down sweep: en=1, up=0 from digit 1 -> digit 0 (tc=1 that cycle), then 9 (DCBA=1010), then 8 (1110). Flip up=1 at digit 8 -> next digit is 9.
- Load: load=1, load_digit=5, en=1 -> next digit=5, DCBA=1100, no count step, tc=0 in the load cycle. Then load_digit=12 with en=1 -> state stays 5, load_err=1 for one cycle.
- Reset mid-operation: rst asserted at digit 6 with en=1 and load=1, load_digit=3 -> next digit=START_DIGIT. Counting resumes from there the cycle after rst drops.
- Cascade: two instances, units.tc drives tens.en, run 100 up-steps from 00 -> returns to 00. tens increments only on the units 9->0 edge. Formal/assertion: every DCBA value is one of the 10 table codes.
